ad9226_sample_packer: RTL
=========================

Name: ad9226_sample_packer

Overview:
Parametrised successor to the single-channel AD9226 sample accumulator. It packs SAMPLES consecutive accepted ADC words into one FIFO write word. It adds a programmable decimation ratio, optional offset-binary to two's-complement conversion, an enable/flush control and saturating drop accounting for FIFO back-pressure. It sits between the AD9226 capture register and the sample FIFO that feeds the W5500 transmit path.

Parameters:
ADC_BITS, 12, width of one ADC sample
SAMPLES, 4, samples packed per FIFO word (>=2)
DECIM_W, 8, width of the decimation ratio input
DROP_W, 16, width of the dropped-word counter

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  packing enable; low = idle, partial word discarded
sample_valid  in  1  data_in carries a new ADC sample this cycle
data_in  in  ADC_BITS  raw AD9226 sample (offset binary)
decim  in  DECIM_W  keep 1 of every decim+1 valid samples (0 = keep all)
fmt_twos  in  1  1 = invert MSB of each kept sample (two's complement)
fifo_full  in  1  downstream FIFO full
clear_drops  in  1  single-cycle pulse; clears drop_count and overflow
fifo_write_enable  out  1  single-cycle write strobe
data_out  out  ADC_BITS*SAMPLES  packed word; sample 0 in LSBs
drop_count  out  DROP_W  words discarded due to fifo_full, saturating
overflow  out  1  sticky: at least one word dropped since last clear

Behaviour:
- Reset (async, reset=1): fifo_write_enable=0, data_out=0, drop_count=0, overflow=0. Slot index, decimation counter and sample buffer are cleared to 0.
- Accept condition: enable & sample_valid & (dec_cnt==0).
- Decimation counter dec_cnt:
  - Advances on every enable & sample_valid.
  - Wraps to 0 after reaching the latched ratio.
  - decim is latched into the latched ratio only when dec_cnt==0 and a valid sample arrives, so mid-period changes apply from the next period.
- On accept:
  - Sample, MSB-inverted if fmt_twos=1, is written to slot[idx].
  - idx increments.
  - idx wraps to 0 after slot SAMPLES-1; the word is complete on that accept.
- Output timing:
  - On the cycle after a completing accept, if fifo_full was 0 during the completing cycle: data_out = {slot[SAMPLES-1], ..., slot[0]} including the just-accepted sample, and fifo_write_enable=1 for exactly one cycle.
  - Latency from the last sample on data_in to strobe: 1 cycle.
- Drop:
  - If fifo_full=1 during the completing cycle: no strobe and data_out holds its previous value.
  - drop_count increments, saturating at 2^DROP_W-1; overflow is set.
  - Packing continues without stall; the ADC stream cannot be paused.
- data_out holds its last written value whenever no strobe is issued.
- Back-to-back: with decim=0 and sample_valid held high, strobes occur every SAMPLES cycles with no gap or lost sample.
- enable low:
  - idx and dec_cnt are forced to 0; partially filled slots are discarded, never written.
  - A completing accept in the last enabled cycle still produces its strobe next cycle.
- clear_drops:
  - Clears drop_count and overflow.
  - If a drop occurs in the same cycle, the result is drop_count=1, overflow=1.
- fifo_full has no effect on non-completing cycles.
- Reset mid-word: all partial state lost; the first word after reset starts at slot 0.

Test Plan:
- Reset release, enable=1, decim=0, fmt_twos=0, sample_valid=1, data_in=0x001,0x002,0x003,0x004 -> one cycle after 0x004, fifo_write_enable=1 with data_out=0x004003002001, then 0 for the next 3 cycles.
- fmt_twos=1, samples 0x800,0x7FF,0x000,0xFFF -> data_out=0x7FF800FFF000.
- decim=2, data_in counting 0..11 each cycle -> one word 0x009006003000; strobe 1 cycle after data_in=9.
- fifo_full=1 on the completing cycles of 3 consecutive words, then 0 -> no strobe for those 3 words, drop_count=3, overflow=1. The next word is written normally with samples following the drops. clear_drops -> drop_count=0, overflow=0.
- enable dropped after 2 samples, re-enabled, then 4 samples 0xA..0xD -> single word 0x00D00C00B00A; the stale partial samples never appear.
- DROP_W=2 build, 5 drops -> drop_count saturates at 3. clear_drops coincident with a 6th drop -> drop_count=1.

Source files
------------

// File: rtl/ad9226_sample_packer.sv
// ---------------------------------------------------------------------------
// ad9226_sample_packer
//
// Packs SAMPLES consecutive accepted AD9226 samples into one FIFO write word.
// Features: programmable decimation (keep 1 of every decim+1 valid samples),
// optional offset-binary to two's-complement conversion (MSB inversion), an
// enable that discards partially filled words, and saturating accounting of
// words dropped because the downstream FIFO was full.
//
// Handshake: sample_valid is a one-cycle "data_in is new" qualifier with no
// ready path back to the ADC; the stream can never be stalled. A completed
// word is written with a single-cycle fifo_write_enable strobe one cycle
// after its last sample, but only if fifo_full was low in the completing
// cycle; otherwise the word is dropped and counted.
//
// Ports:
//   sys_clk            system clock (rising edge)
//   reset              asynchronous, active-high reset
//   enable             packing enable; low forces slot/decimation to 0
//   sample_valid       data_in carries a new sample this cycle
//   data_in            raw AD9226 sample (offset binary)
//   decim              decimation ratio, latched at the start of a period
//   fmt_twos           1 = invert MSB of each kept sample
//   fifo_full          downstream FIFO full (sampled on completing cycles)
//   clear_drops        pulse; clears drop_count and overflow
//   fifo_write_enable  single-cycle write strobe
//   data_out           packed word, sample 0 in the LSBs
//   drop_count         saturating count of dropped words
//   overflow           sticky flag, set by any drop since the last clear
// ---------------------------------------------------------------------------
module ad9226_sample_packer #(
   parameter int ADC_BITS = 12,
   parameter int SAMPLES  = 4,
   parameter int DECIM_W  = 8,
   parameter int DROP_W   = 16
) (
   input  logic                         sys_clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         sample_valid,
   input  logic [ADC_BITS-1:0]          data_in,
   input  logic [DECIM_W-1:0]           decim,
   input  logic                         fmt_twos,
   input  logic                         fifo_full,
   input  logic                         clear_drops,
   output logic                         fifo_write_enable,
   output logic [ADC_BITS*SAMPLES-1:0]  data_out,
   output logic [DROP_W-1:0]            drop_count,
   output logic                         overflow
);

   localparam int                IDX_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SAMPLES - 1);

   logic [IDX_W-1:0]                    idx_q, idx_d;
   logic [DECIM_W-1:0]                  dec_cnt_q, dec_cnt_d;
   logic [DECIM_W-1:0]                  ratio_q, ratio_d;
   logic [SAMPLES-1:0][ADC_BITS-1:0]    slot_q, slot_d;
   logic                                wen_q, wen_d;
   logic [ADC_BITS*SAMPLES-1:0]         dout_q, dout_d;
   logic [DROP_W-1:0]                   drop_q, drop_d;
   logic                                ovf_q, ovf_d;

   logic                                accept;
   logic                                complete;
   logic                                drop;
   logic [DECIM_W-1:0]                  ratio_eff;
   logic [ADC_BITS-1:0]                 sample_fmt;

   always_comb begin
      idx_d      = idx_q;
      dec_cnt_d  = dec_cnt_q;
      ratio_d    = ratio_q;
      slot_d     = slot_q;
      wen_d      = 1'b0;
      dout_d     = dout_q;
      drop_d     = drop_q;
      ovf_d      = ovf_q;
      drop       = 1'b0;

      // At the start of a period the ratio in force is the one being latched
      // this cycle, so a period of length decim+1 begins immediately.
      ratio_eff  = (dec_cnt_q == '0) ? decim : ratio_q;
      accept     = enable & sample_valid & (dec_cnt_q == '0);
      complete   = accept & (idx_q == LAST_IDX);

      sample_fmt                 = data_in;
      sample_fmt[ADC_BITS-1]     = data_in[ADC_BITS-1] ^ fmt_twos;

      if (!enable) begin
         idx_d     = '0;
         dec_cnt_d = '0;
      end else if (sample_valid) begin
         if (dec_cnt_q == '0) begin
            ratio_d = decim;
         end
         dec_cnt_d = (dec_cnt_q == ratio_eff) ? '0 : dec_cnt_q + 1'b1;
      end

      if (accept) begin
         slot_d[idx_q] = sample_fmt;
         idx_d         = complete ? '0 : idx_q + 1'b1;
      end

      // slot_d already holds the just-accepted sample in the top slot.
      if (complete) begin
         if (!fifo_full) begin
            dout_d = slot_d;
            wen_d  = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      // A clear coincident with a drop leaves exactly that one drop counted.
      if (clear_drops) begin
         drop_d = drop ? DROP_W'(1) : '0;
         ovf_d  = drop;
      end else if (drop) begin
         if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
         end
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         idx_q     <= '0;
         dec_cnt_q <= '0;
         ratio_q   <= '0;
         slot_q    <= '0;
         wen_q     <= 1'b0;
         dout_q    <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         dec_cnt_q <= dec_cnt_d;
         ratio_q   <= ratio_d;
         slot_q    <= slot_d;
         wen_q     <= wen_d;
         dout_q    <= dout_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
      end
   end

   assign fifo_write_enable = wen_q;
   assign data_out          = dout_q;
   assign drop_count        = drop_q;
   assign overflow          = ovf_q;

endmodule
